// File: rtl/serial_parity_checker_if.sv
// Handshake and data bundle between the data sampler / receive FSM and the
// serial parity checker. The checker attaches through the slave modport; the
// master modport is the view of whatever drives the sampled bits.
//   Inputs to the checker : Start, Len, Mode, Bit/Bit_Valid, Par_Bit/Par_Valid, Cnt_Clr
//   Outputs from checker  : PDATA, Done, Par_err, Seq_err, Err_Sticky, Err_Cnt, Busy
interface serial_parity_checker_if #(
    parameter int unsigned MAX_WIDTH = 9,
    parameter int unsigned LEN_WIDTH = 4,
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 SerPar_Start;
    logic [LEN_WIDTH-1:0] SerPar_Len;
    logic [1:0]           SerPar_Mode;
    logic                 SerPar_Bit;
    logic                 SerPar_Bit_Valid;
    logic                 SerPar_Par_Bit;
    logic                 SerPar_Par_Valid;
    logic                 SerPar_Cnt_Clr;
    logic [MAX_WIDTH-1:0] SerPar_PDATA;
    logic                 SerPar_Done;
    logic                 SerPar_Par_err;
    logic                 SerPar_Seq_err;
    logic                 SerPar_Err_Sticky;
    logic [CNT_WIDTH-1:0] SerPar_Err_Cnt;
    logic                 SerPar_Busy;

    modport master (
        output SerPar_Start, SerPar_Len, SerPar_Mode, SerPar_Bit, SerPar_Bit_Valid,
               SerPar_Par_Bit, SerPar_Par_Valid, SerPar_Cnt_Clr,
        input  SerPar_PDATA, SerPar_Done, SerPar_Par_err, SerPar_Seq_err,
               SerPar_Err_Sticky, SerPar_Err_Cnt, SerPar_Busy
    );

    modport slave (
        input  SerPar_Start, SerPar_Len, SerPar_Mode, SerPar_Bit, SerPar_Bit_Valid,
               SerPar_Par_Bit, SerPar_Par_Valid, SerPar_Cnt_Clr,
        output SerPar_PDATA, SerPar_Done, SerPar_Par_err, SerPar_Seq_err,
               SerPar_Err_Sticky, SerPar_Err_Cnt, SerPar_Busy
    );
endinterface

// File: rtl/serial_parity_checker.sv
// Bit-serial parity checker for the UART receive path. Parity is accumulated
// as data bits arrive, so the deserialised word is only assembled for readout.
// Ports:
//   SerPar_CLK  clock
//   SerPar_RST  synchronous active-high reset
//   bus         serial_parity_checker_if.slave; parameters of the attached
//               interface instance must match this module's parameters
// Frame flow: Start (latch Len/Mode) -> DATA (Len bits) -> PARITY (one parity
// bit) -> Done/Par_err pulse. Protocol violations pulse Seq_err. A sticky flag
// and a saturating counter record parity errors until Cnt_Clr.
module serial_parity_checker #(
    parameter int unsigned MAX_WIDTH = 9,
    parameter int unsigned LEN_WIDTH = 4,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                     SerPar_CLK,
    input  logic                     SerPar_RST,
    serial_parity_checker_if.slave   bus
);
    typedef enum logic [1:0] {StIdle, StData, StParity} stateT;

    stateT                stateQ, stateD;
    logic [LEN_WIDTH-1:0] lenQ, lenD;
    logic [1:0]           modeQ, modeD;
    logic                 accQ, accD;
    logic [LEN_WIDTH-1:0] bitCntQ, bitCntD;
    logic [MAX_WIDTH-1:0] pDataQ, pDataD;
    logic                 doneQ, doneD;
    logic                 parErrQ, parErrD;
    logic                 seqErrQ, seqErrD;
    logic                 stickyQ, stickyD;
    logic [CNT_WIDTH-1:0] errCntQ, errCntD;

    logic                 startLegal;
    logic                 expParity;
    logic [LEN_WIDTH-1:0] bitCntInc;

    assign startLegal = (bus.SerPar_Len != '0) && (bus.SerPar_Len <= LEN_WIDTH'(MAX_WIDTH));
    assign bitCntInc  = bitCntQ + LEN_WIDTH'(1);

    always_comb begin
        expParity = 1'b0;
        unique case (modeQ)
            2'b00:   expParity = accQ;
            2'b01:   expParity = ~accQ;
            2'b10:   expParity = 1'b1;
            default: expParity = 1'b0;
        endcase
    end

    always_comb begin
        stateD  = stateQ;
        lenD    = lenQ;
        modeD   = modeQ;
        accD    = accQ;
        bitCntD = bitCntQ;
        pDataD  = pDataQ;
        doneD   = 1'b0;
        parErrD = 1'b0;
        seqErrD = 1'b0;
        stickyD = stickyQ;
        errCntD = errCntQ;

        // Both strobes at once is illegal in every state.
        if (bus.SerPar_Bit_Valid && bus.SerPar_Par_Valid) begin
            seqErrD = 1'b1;
        end

        if (bus.SerPar_Start) begin
            // A Start always begins a fresh frame; a running one is dropped
            // without Done.
            if (stateQ != StIdle) begin
                seqErrD = 1'b1;
            end
            accD    = 1'b0;
            bitCntD = '0;
            pDataD  = '0;
            if (startLegal) begin
                stateD = StData;
                lenD   = bus.SerPar_Len;
                modeD  = bus.SerPar_Mode;
            end else begin
                stateD  = StIdle;
                seqErrD = 1'b1;
            end
        end else begin
            unique case (stateQ)
                StData: begin
                    if (bus.SerPar_Par_Valid) begin
                        seqErrD = 1'b1;
                    end
                    if (bus.SerPar_Bit_Valid) begin
                        accD    = accQ ^ bus.SerPar_Bit;
                        bitCntD = bitCntInc;
                        for (int i = 0; i < int'(MAX_WIDTH); i++) begin
                            if (bitCntQ == LEN_WIDTH'(i)) begin
                                pDataD[i] = bus.SerPar_Bit;
                            end
                        end
                        if (bitCntInc == lenQ) begin
                            stateD = StParity;
                        end
                    end
                end
                StParity: begin
                    if (bus.SerPar_Bit_Valid) begin
                        seqErrD = 1'b1;
                    end
                    if (bus.SerPar_Par_Valid) begin
                        parErrD = expParity ^ bus.SerPar_Par_Bit;
                        doneD   = 1'b1;
                        stateD  = StIdle;
                    end
                end
                default: ;
            endcase
        end

        // Status is updated on the same edge that registers Par_err; clear wins.
        if (bus.SerPar_Cnt_Clr) begin
            stickyD = 1'b0;
            errCntD = '0;
        end else if (parErrD) begin
            stickyD = 1'b1;
            if (errCntQ != '1) begin
                errCntD = errCntQ + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge SerPar_CLK) begin
        if (SerPar_RST) begin
            stateQ  <= StIdle;
            lenQ    <= '0;
            modeQ   <= 2'b00;
            accQ    <= 1'b0;
            bitCntQ <= '0;
            pDataQ  <= '0;
            doneQ   <= 1'b0;
            parErrQ <= 1'b0;
            seqErrQ <= 1'b0;
            stickyQ <= 1'b0;
            errCntQ <= '0;
        end else begin
            stateQ  <= stateD;
            lenQ    <= lenD;
            modeQ   <= modeD;
            accQ    <= accD;
            bitCntQ <= bitCntD;
            pDataQ  <= pDataD;
            doneQ   <= doneD;
            parErrQ <= parErrD;
            seqErrQ <= seqErrD;
            stickyQ <= stickyD;
            errCntQ <= errCntD;
        end
    end

    assign bus.SerPar_PDATA      = pDataQ;
    assign bus.SerPar_Done       = doneQ;
    assign bus.SerPar_Par_err    = parErrQ;
    assign bus.SerPar_Seq_err    = seqErrQ;
    assign bus.SerPar_Err_Sticky = stickyQ;
    assign bus.SerPar_Err_Cnt    = errCntQ;
    assign bus.SerPar_Busy       = (stateQ != StIdle);
endmodule

// File: tb/tb_serial_parity_checker.sv
module tb_serial_parity_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_parity_checker_if #(.MAX_WIDTH(9), .LEN_WIDTH(4), .CNT_WIDTH(8)) bus ();
    serial_parity_checker_if #(.MAX_WIDTH(9), .LEN_WIDTH(4), .CNT_WIDTH(2)) bus2 ();

    // Second instance sees identical stimulus; only its narrow counter is checked.
    assign bus2.SerPar_Start     = bus.SerPar_Start;
    assign bus2.SerPar_Len       = bus.SerPar_Len;
    assign bus2.SerPar_Mode      = bus.SerPar_Mode;
    assign bus2.SerPar_Bit       = bus.SerPar_Bit;
    assign bus2.SerPar_Bit_Valid = bus.SerPar_Bit_Valid;
    assign bus2.SerPar_Par_Bit   = bus.SerPar_Par_Bit;
    assign bus2.SerPar_Par_Valid = bus.SerPar_Par_Valid;
    assign bus2.SerPar_Cnt_Clr   = bus.SerPar_Cnt_Clr;

    serial_parity_checker #(.MAX_WIDTH(9), .LEN_WIDTH(4), .CNT_WIDTH(8)) dut (
        .SerPar_CLK (clk),
        .SerPar_RST (rst),
        .bus        (bus)
    );

    serial_parity_checker #(.MAX_WIDTH(9), .LEN_WIDTH(4), .CNT_WIDTH(2)) dut2 (
        .SerPar_CLK (clk),
        .SerPar_RST (rst),
        .bus        (bus2)
    );

    // Inputs are changed and outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic startFrame(input logic [3:0] len, input logic [1:0] mode);
        bus.SerPar_Start = 1'b1;
        bus.SerPar_Len   = len;
        bus.SerPar_Mode  = mode;
        step();
        bus.SerPar_Start = 1'b0;
    endtask

    task automatic sendBits(input int n, input logic [15:0] data);
        for (int i = 0; i < n; i++) begin
            bus.SerPar_Bit       = data[i];
            bus.SerPar_Bit_Valid = 1'b1;
            step();
        end
        bus.SerPar_Bit_Valid = 1'b0;
        bus.SerPar_Bit       = 1'b0;
    endtask

    task automatic sendParity(input logic p);
        bus.SerPar_Par_Bit   = p;
        bus.SerPar_Par_Valid = 1'b1;
        step();
        bus.SerPar_Par_Valid = 1'b0;
        bus.SerPar_Par_Bit   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (bus.SerPar_PDATA !== 9'h000 || bus.SerPar_Done !== 1'b0 ||
            bus.SerPar_Par_err !== 1'b0 || bus.SerPar_Seq_err !== 1'b0 ||
            bus.SerPar_Err_Sticky !== 1'b0 || bus.SerPar_Err_Cnt !== 8'd0 ||
            bus.SerPar_Busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: pdata=%h done=%b perr=%b seq=%b sticky=%b cnt=%0d busy=%b required all 0",
                     bus.SerPar_PDATA, bus.SerPar_Done, bus.SerPar_Par_err, bus.SerPar_Seq_err,
                     bus.SerPar_Err_Sticky, bus.SerPar_Err_Cnt, bus.SerPar_Busy);
        end
    endtask

    task automatic test_even();
        startFrame(4'd8, 2'b00);
        checks++;
        if (bus.SerPar_Busy !== 1'b1) begin
            failures++;
            $display("FAIL even_busy: got %b required 1", bus.SerPar_Busy);
        end
        bus.SerPar_Mode = 2'b01;  // mid-frame mode change must not matter
        sendBits(8, 16'h00A5);
        checks++;
        if (bus.SerPar_Done !== 1'b0) begin
            failures++;
            $display("FAIL even_done_early: got %b required 0", bus.SerPar_Done);
        end
        sendParity(1'b0);
        checks++;
        if (bus.SerPar_Done !== 1'b1 || bus.SerPar_Par_err !== 1'b0) begin
            failures++;
            $display("FAIL even_result: done=%b perr=%b required done=1 perr=0",
                     bus.SerPar_Done, bus.SerPar_Par_err);
        end
        checks++;
        if (bus.SerPar_PDATA !== 9'h0A5 || bus.SerPar_Err_Cnt !== 8'd0) begin
            failures++;
            $display("FAIL even_pdata_cnt: pdata=%h cnt=%0d required 0a5 0",
                     bus.SerPar_PDATA, bus.SerPar_Err_Cnt);
        end
        step();
        checks++;
        if (bus.SerPar_Done !== 1'b0 || bus.SerPar_Busy !== 1'b0 || bus.SerPar_PDATA !== 9'h0A5) begin
            failures++;
            $display("FAIL even_after: done=%b busy=%b pdata=%h required 0 0 0a5",
                     bus.SerPar_Done, bus.SerPar_Busy, bus.SerPar_PDATA);
        end
    endtask

    task automatic test_odd_and_clear();
        startFrame(4'd8, 2'b01);
        sendBits(8, 16'h00A5);
        sendParity(1'b0);
        checks++;
        if (bus.SerPar_Done !== 1'b1 || bus.SerPar_Par_err !== 1'b1 ||
            bus.SerPar_Err_Sticky !== 1'b1 || bus.SerPar_Err_Cnt !== 8'd1) begin
            failures++;
            $display("FAIL odd_error: done=%b perr=%b sticky=%b cnt=%0d required 1 1 1 1",
                     bus.SerPar_Done, bus.SerPar_Par_err, bus.SerPar_Err_Sticky, bus.SerPar_Err_Cnt);
        end
        step();
        checks++;
        if (bus.SerPar_Par_err !== 1'b0 || bus.SerPar_Err_Sticky !== 1'b1) begin
            failures++;
            $display("FAIL odd_hold: perr=%b sticky=%b required 0 1",
                     bus.SerPar_Par_err, bus.SerPar_Err_Sticky);
        end
        bus.SerPar_Cnt_Clr = 1'b1;
        step();
        bus.SerPar_Cnt_Clr = 1'b0;
        checks++;
        if (bus.SerPar_Err_Cnt !== 8'd0 || bus.SerPar_Err_Sticky !== 1'b0) begin
            failures++;
            $display("FAIL odd_clear: cnt=%0d sticky=%b required 0 0",
                     bus.SerPar_Err_Cnt, bus.SerPar_Err_Sticky);
        end
        // Clear coinciding with an error increment: clear wins.
        startFrame(4'd8, 2'b01);
        sendBits(8, 16'h00A5);
        bus.SerPar_Cnt_Clr = 1'b1;
        sendParity(1'b0);
        bus.SerPar_Cnt_Clr = 1'b0;
        checks++;
        if (bus.SerPar_Par_err !== 1'b1 || bus.SerPar_Err_Cnt !== 8'd0 ||
            bus.SerPar_Err_Sticky !== 1'b0) begin
            failures++;
            $display("FAIL clear_wins: perr=%b cnt=%0d sticky=%b required 1 0 0",
                     bus.SerPar_Par_err, bus.SerPar_Err_Cnt, bus.SerPar_Err_Sticky);
        end
        step();
    endtask

    task automatic test_mark_space();
        startFrame(4'd7, 2'b10);
        sendBits(7, 16'h007F);
        sendParity(1'b0);
        checks++;
        if (bus.SerPar_Done !== 1'b1 || bus.SerPar_Par_err !== 1'b1) begin
            failures++;
            $display("FAIL mark_error: done=%b perr=%b required 1 1",
                     bus.SerPar_Done, bus.SerPar_Par_err);
        end
        step();
        startFrame(4'd7, 2'b11);
        sendBits(7, 16'h007F);
        sendParity(1'b0);
        checks++;
        if (bus.SerPar_Done !== 1'b1 || bus.SerPar_Par_err !== 1'b0 || bus.SerPar_PDATA !== 9'h07F) begin
            failures++;
            $display("FAIL space_ok: done=%b perr=%b pdata=%h required 1 0 07f",
                     bus.SerPar_Done, bus.SerPar_Par_err, bus.SerPar_PDATA);
        end
        step();
    endtask

    task automatic test_back_to_back();
        startFrame(4'd8, 2'b00);
        sendBits(3, 16'h0007);
        startFrame(4'd5, 2'b00);
        checks++;
        if (bus.SerPar_Seq_err !== 1'b1 || bus.SerPar_Done !== 1'b0 || bus.SerPar_Busy !== 1'b1 ||
            bus.SerPar_PDATA !== 9'h000) begin
            failures++;
            $display("FAIL restart: seq=%b done=%b busy=%b pdata=%h required 1 0 1 000",
                     bus.SerPar_Seq_err, bus.SerPar_Done, bus.SerPar_Busy, bus.SerPar_PDATA);
        end
        sendBits(5, 16'h0015);
        checks++;
        if (bus.SerPar_Seq_err !== 1'b0 || bus.SerPar_Done !== 1'b0) begin
            failures++;
            $display("FAIL restart_bits: seq=%b done=%b required 0 0",
                     bus.SerPar_Seq_err, bus.SerPar_Done);
        end
        sendParity(1'b1);
        checks++;
        if (bus.SerPar_Done !== 1'b1 || bus.SerPar_Par_err !== 1'b0 || bus.SerPar_PDATA !== 9'h015) begin
            failures++;
            $display("FAIL restart_result: done=%b perr=%b pdata=%h required 1 0 015",
                     bus.SerPar_Done, bus.SerPar_Par_err, bus.SerPar_PDATA);
        end
        step();
    endtask

    task automatic test_seq_errors();
        startFrame(4'd4, 2'b00);
        bus.SerPar_Par_Valid = 1'b1;
        step();
        bus.SerPar_Par_Valid = 1'b0;
        checks++;
        if (bus.SerPar_Seq_err !== 1'b1 || bus.SerPar_Busy !== 1'b1 || bus.SerPar_Done !== 1'b0) begin
            failures++;
            $display("FAIL par_in_data: seq=%b busy=%b done=%b required 1 1 0",
                     bus.SerPar_Seq_err, bus.SerPar_Busy, bus.SerPar_Done);
        end
        sendBits(4, 16'h0003);
        bus.SerPar_Bit       = 1'b1;
        bus.SerPar_Bit_Valid = 1'b1;
        step();
        bus.SerPar_Bit_Valid = 1'b0;
        bus.SerPar_Bit       = 1'b0;
        checks++;
        if (bus.SerPar_Seq_err !== 1'b1 || bus.SerPar_Done !== 1'b0) begin
            failures++;
            $display("FAIL bit_in_parity: seq=%b done=%b required 1 0",
                     bus.SerPar_Seq_err, bus.SerPar_Done);
        end
        sendParity(1'b0);
        checks++;
        if (bus.SerPar_Done !== 1'b1 || bus.SerPar_Par_err !== 1'b0 || bus.SerPar_PDATA !== 9'h003) begin
            failures++;
            $display("FAIL seq_frame_result: done=%b perr=%b pdata=%h required 1 0 003",
                     bus.SerPar_Done, bus.SerPar_Par_err, bus.SerPar_PDATA);
        end
        startFrame(4'd0, 2'b00);
        checks++;
        if (bus.SerPar_Seq_err !== 1'b1 || bus.SerPar_Busy !== 1'b0 || bus.SerPar_PDATA !== 9'h000) begin
            failures++;
            $display("FAIL len_zero: seq=%b busy=%b pdata=%h required 1 0 000",
                     bus.SerPar_Seq_err, bus.SerPar_Busy, bus.SerPar_PDATA);
        end
        startFrame(4'd10, 2'b00);
        checks++;
        if (bus.SerPar_Seq_err !== 1'b1 || bus.SerPar_Busy !== 1'b0) begin
            failures++;
            $display("FAIL len_too_big: seq=%b busy=%b required 1 0",
                     bus.SerPar_Seq_err, bus.SerPar_Busy);
        end
        bus.SerPar_Bit_Valid = 1'b1;
        bus.SerPar_Par_Valid = 1'b1;
        step();
        bus.SerPar_Bit_Valid = 1'b0;
        bus.SerPar_Par_Valid = 1'b0;
        checks++;
        if (bus.SerPar_Seq_err !== 1'b1 || bus.SerPar_Busy !== 1'b0 || bus.SerPar_Done !== 1'b0) begin
            failures++;
            $display("FAIL both_strobes_idle: seq=%b busy=%b done=%b required 1 0 0",
                     bus.SerPar_Seq_err, bus.SerPar_Busy, bus.SerPar_Done);
        end
        // Full-width frame: nine ones, even parity expects 1.
        startFrame(4'd9, 2'b00);
        sendBits(9, 16'h01FF);
        sendParity(1'b1);
        checks++;
        if (bus.SerPar_Done !== 1'b1 || bus.SerPar_Par_err !== 1'b0 || bus.SerPar_PDATA !== 9'h1FF) begin
            failures++;
            $display("FAIL max_len: done=%b perr=%b pdata=%h required 1 0 1ff",
                     bus.SerPar_Done, bus.SerPar_Par_err, bus.SerPar_PDATA);
        end
        step();
    endtask

    task automatic test_saturation();
        logic [1:0] exp2;
        bus.SerPar_Cnt_Clr = 1'b1;
        step();
        bus.SerPar_Cnt_Clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            startFrame(4'd1, 2'b10);
            sendBits(1, 16'h0000);
            sendParity(1'b0);
            exp2 = (i < 3) ? 2'(i + 1) : 2'd3;
            checks++;
            if (bus2.SerPar_Err_Cnt !== exp2 || bus.SerPar_Err_Cnt !== 8'(i + 1)) begin
                failures++;
                $display("FAIL sat_cnt[%0d]: narrow=%0d wide=%0d required %0d %0d",
                         i, bus2.SerPar_Err_Cnt, bus.SerPar_Err_Cnt, exp2, i + 1);
            end
            step();
        end
    endtask

    task automatic test_reset_in_parity();
        startFrame(4'd2, 2'b00);
        sendBits(2, 16'h0003);
        checks++;
        if (bus.SerPar_Busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_busy: got %b required 1", bus.SerPar_Busy);
        end
        rst = 1'b1;
        bus.SerPar_Par_Valid = 1'b1;
        step();
        checks++;
        if (bus.SerPar_Busy !== 1'b0 || bus.SerPar_Done !== 1'b0 || bus.SerPar_PDATA !== 9'h000 ||
            bus.SerPar_Err_Cnt !== 8'd0 || bus.SerPar_Err_Sticky !== 1'b0 ||
            bus.SerPar_Seq_err !== 1'b0 || bus.SerPar_Par_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_frame: busy=%b done=%b pdata=%h cnt=%0d sticky=%b seq=%b perr=%b required all 0",
                     bus.SerPar_Busy, bus.SerPar_Done, bus.SerPar_PDATA, bus.SerPar_Err_Cnt,
                     bus.SerPar_Err_Sticky, bus.SerPar_Seq_err, bus.SerPar_Par_err);
        end
        rst = 1'b0;
        step();
        bus.SerPar_Par_Valid = 1'b0;
        checks++;
        if (bus.SerPar_Done !== 1'b0 || bus.SerPar_Busy !== 1'b0 || bus2.SerPar_Err_Cnt !== 2'd0) begin
            failures++;
            $display("FAIL rst_then_par: done=%b busy=%b narrow_cnt=%0d required 0 0 0",
                     bus.SerPar_Done, bus.SerPar_Busy, bus2.SerPar_Err_Cnt);
        end
    endtask

    initial begin
        bus.SerPar_Start     = 1'b0;
        bus.SerPar_Len       = 4'd0;
        bus.SerPar_Mode      = 2'b00;
        bus.SerPar_Bit       = 1'b0;
        bus.SerPar_Bit_Valid = 1'b0;
        bus.SerPar_Par_Bit   = 1'b0;
        bus.SerPar_Par_Valid = 1'b0;
        bus.SerPar_Cnt_Clr   = 1'b0;
        test_reset();
        test_even();
        test_odd_and_clear();
        test_mark_space();
        test_back_to_back();
        test_seq_errors();
        test_saturation();
        test_reset_in_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
Bit-serial successor to the combinational parity checker in the UART receive path. It accumulates parity as data bits arrive from the sampler, so it no longer needs the deserialised word. It supports a runtime frame length, four parity modes, and a per-frame error result with handshake. It also keeps a sticky error flag and a saturating error counter for status readout, and sits between the data sampler and the receive FSM.

Parameters:
MAX_WIDTH, 9, maximum data bits per frame; legal range 5..16.
LEN_WIDTH, 4, width of the frame-length input; must satisfy 2^LEN_WIDTH > MAX_WIDTH.
CNT_WIDTH, 8, width of the saturating parity-error counter.

Ports:
SerPar_CLK  in  1  clock.
SerPar_RST  in  1  synchronous, active-high reset.
SerPar_Start  in  1  1-cycle pulse at start-bit acceptance; latches config, clears accumulator.
SerPar_Len  in  LEN_WIDTH  data bits in this frame; legal 1..MAX_WIDTH.
SerPar_Mode  in  2  parity mode: 00 even, 01 odd, 10 mark (expect 1), 11 space (expect 0).
SerPar_Bit  in  1  sampled data bit, LSB first.
SerPar_Bit_Valid  in  1  qualifies SerPar_Bit, at most one per bit period.
SerPar_Par_Bit  in  1  sampled parity bit.
SerPar_Par_Valid  in  1  qualifies SerPar_Par_Bit.
SerPar_Cnt_Clr  in  1  clears the counter and the sticky flag.
SerPar_PDATA  out  MAX_WIDTH  assembled data, LSB-aligned, upper unused bits 0.
SerPar_Done  out  1  1-cycle pulse when the frame check completes.
SerPar_Par_err  out  1  valid only with Done; 1 means parity mismatch.
SerPar_Seq_err  out  1  1-cycle pulse on a protocol violation.
SerPar_Err_Sticky  out  1  set by any Par_err; held until clear or reset.
SerPar_Err_Cnt  out  CNT_WIDTH  count of parity errors, saturating.
SerPar_Busy  out  1  high in DATA or PARITY state.

Behaviour:
- Reset (sync, SerPar_RST=1 at the clock edge):
  - State goes to IDLE.
  - PDATA, Done, Par_err, Seq_err, Err_Sticky, Err_Cnt and Busy are all 0.
  - The accumulator and bit counter are 0.
  - Reset overrides every other input in the same cycle, including reset arriving mid-frame.
- FSM states are IDLE, DATA and PARITY.
- IDLE:
  - Start moves to DATA.
  - On that transition, Len and Mode are latched, acc=0, bitcnt=0 and PDATA=0.
  - Bit_Valid and Par_Valid are ignored.
- DATA:
  - Each Bit_Valid does acc^=Bit, PDATA[bitcnt]=Bit, bitcnt++.
  - When the incremented bitcnt equals the latched Len, move to PARITY.
- PARITY:
  - On Par_Valid, compute expected: even=acc, odd=~acc, mark=1, space=0.
  - Par_err = expected ^ Par_Bit, with Done=1 for exactly the next cycle, then return to IDLE.
  - Latency is 1 clock from the Par_Valid edge to Done/Par_err registered high.
- Par_err and Done are registered pulses; Par_err is 0 whenever Done is 0.
- On Done with Par_err=1:
  - Err_Sticky goes to 1.
  - Err_Cnt increments, holding at all-ones (2^CNT_WIDTH-1) with no wrap.
- Cnt_Clr in the same cycle as an error increment gives a cleared counter and flag, because clear wins.
- Start while Busy:
  - Pulse Seq_err.
  - Abort the current frame without asserting Done.
  - Restart DATA with the new Len/Mode in the same cycle.
- Par_Valid while in DATA: pulse Seq_err, ignore the bit, stay in DATA.
- Bit_Valid while in PARITY: pulse Seq_err, ignore the bit.
- Bit_Valid and Par_Valid together in any state: Seq_err, and the strobe illegal for the current state is ignored.
- Len=0 or Len>MAX_WIDTH at Start:
  - Pulse Seq_err and stay in IDLE.
  - PDATA is still cleared.
- Mode change mid-frame has no effect; only the value latched at Start is used.
- PDATA holds its last value after Done until the next Start.

Test Plan:
- Len=8, Mode=00, bits 0xA5 LSB first, Par_Bit=0 -> Done 1 cycle after Par_Valid, Par_err=0, PDATA=0x0A5, Err_Cnt=0.
- Len=8, Mode=01, bits 0xA5, Par_Bit=0 -> Par_err=1, Err_Sticky=1, Err_Cnt=1; then Cnt_Clr -> Err_Cnt=0, Err_Sticky=0.
- Len=7, Mode=10, bits 0x7F, Par_Bit=0 -> Par_err=1; repeated with Mode=11, Par_Bit=0 -> Par_err=0; PDATA=0x07F.
- Start again after 3 bits of a Len=8 frame -> Seq_err pulse, no Done, new frame of Len=5 bits 0x15, Mode=00, Par_Bit=1 completes with Par_err=0, PDATA=0x015.
- CNT_WIDTH=2, force 5 consecutive parity errors -> Err_Cnt sequence 1,2,3,3,3.
- Assert RST while in PARITY -> next cycle Busy=0, no Done, all outputs 0; a following Par_Valid produces no Done.
